// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Parses SOF/LEN/payload/CHK frames from a FWFT UART rx FIFO,
//            buffers the payload and replays it over a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         TO_CYC  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rdata,
    output logic       rd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int                c_cnt_w   = $clog2(MAX_LEN + 1);
    localparam int                c_addr_w  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int                c_to_w    = $clog2(TO_CYC + 1);
    localparam logic [7:0]        c_max_len = 8'(MAX_LEN);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TO_CYC - 1);
    localparam logic [1:0]        c_err_len = 2'b01;
    localparam logic [1:0]        c_err_chk = 2'b10;
    localparam logic [1:0]        c_err_to  = 2'b11;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t               state_q,     state_d;
    logic [c_cnt_w-1:0]   len_q,       len_d;
    logic [c_cnt_w-1:0]   wr_idx_q,    wr_idx_d;
    logic [c_cnt_w-1:0]   rd_idx_q,    rd_idx_d;
    logic [7:0]           xor_q,       xor_d;
    logic [c_to_w-1:0]    to_cnt_q,    to_cnt_d;
    logic                 frame_ok_q,  frame_ok_d;
    logic                 frame_err_q, frame_err_d;
    logic [1:0]           err_code_q,  err_code_d;
    logic [7:0]           mem_q [MAX_LEN];
    logic                 w_buf_we;
    logic                 w_rx_state;
    logic                 w_is_last;

    assign w_rx_state = (state_q == S_HUNT) || (state_q == S_LEN) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign w_is_last  = (rd_idx_q == (len_q - c_cnt_w'(1)));

    always_comb begin
        rd        = !rx_empty && !rst && w_rx_state;
        out_valid = !rst && (state_q == S_EMIT);
        out_data  = out_valid ? mem_q[rd_idx_q[c_addr_w-1:0]] : 8'h00;
        out_last  = out_valid && w_is_last;
        frame_ok  = !rst && frame_ok_q;
        frame_err = !rst && frame_err_q;
        err_code  = rst ? 2'b00 : err_code_q;
        busy      = !rst && (state_q != S_HUNT);
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        xor_d       = xor_q;
        to_cnt_d    = '0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        w_buf_we    = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (rd && (rdata == SOF)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rd) begin
                    if ((rdata == 8'h00) || (rdata > c_max_len)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = c_err_len;
                        state_d     = S_HUNT;
                    end else begin
                        len_d    = rdata[c_cnt_w-1:0];
                        xor_d    = rdata;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rd) begin
                    w_buf_we = 1'b1;
                    xor_d    = xor_q ^ rdata;
                    if (wr_idx_q == (len_q - c_cnt_w'(1))) begin
                        state_d = S_CHK;
                    end else begin
                        wr_idx_d = wr_idx_q + c_cnt_w'(1);
                    end
                end
            end
            S_CHK: begin
                if (rd) begin
                    if (rdata == xor_q) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = S_EMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = c_err_chk;
                        state_d     = S_HUNT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (w_is_last) begin
                        state_d = S_HUNT;
                    end else begin
                        rd_idx_d = rd_idx_q + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // Inter-byte timeout only while a frame is being received.
        if ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK)) begin
            if (!rd && rx_empty) begin
                if (to_cnt_q == c_to_last) begin
                    frame_err_d = 1'b1;
                    err_code_d  = c_err_to;
                    state_d     = S_HUNT;
                end else begin
                    to_cnt_d = to_cnt_q + c_to_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            xor_q       <= 8'h00;
            to_cnt_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            xor_q       <= xor_d;
            to_cnt_q    <= to_cnt_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload store needs no reset: it is only read back after being written.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            mem_q[wr_idx_q[c_addr_w-1:0]] <= rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Brief    : Directed self-checking bench for uart_frame_parser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int TO = 32;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_empty  = 1'b1;
    logic [7:0] rdata     = 8'h00;
    logic       out_ready = 1'b1;
    logic       rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_frame_parser #(
        .SOF     (8'hA5),
        .MAX_LEN (16),
        .TO_CYC  (TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .rdata     (rdata),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    logic [7:0] fifo [$];
    logic [7:0] outq [$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  pop_pend = 1'b0;
    bit  toggle_mode = 1'b0;
    int  ok_cnt, err_cnt, last_cnt, valid_cnt, rd_emit_viol, stall_viol, stall_cnt;
    int  last_pop_cyc, err_cyc;
    logic [7:0] last_byte;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // FIFO model, sink and monitor: inputs change on negedge, outputs sampled 2ns later.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        pop_pend  = 1'b0;
        rx_empty  = (fifo.size() == 0);
        rdata     = rx_empty ? 8'h00 : fifo[0];
        out_ready = toggle_mode ? ~out_ready : 1'b1;
        #2;
        if (rd) begin
            pop_pend     = 1'b1;
            last_pop_cyc = cyc;
        end
        if (frame_ok) ok_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (out_valid) valid_cnt++;
        if (rd && out_valid) rd_emit_viol++;
        if (prev_stall && out_valid && (out_data !== prev_data)) stall_viol++;
        if (out_valid && !out_ready) stall_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            if (out_last) begin
                last_cnt++;
                last_byte = out_data;
            end
        end
    end

    task automatic put(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic clear_stats();
        ok_cnt = 0; err_cnt = 0; last_cnt = 0; valid_cnt = 0;
        rd_emit_viol = 0; stall_viol = 0; stall_cnt = 0;
        err_cyc = 0; last_byte = 8'h00;
        outq.delete();
    endtask

    task automatic wait_idle(input string tag);
        int idle = 0;
        int n    = 0;
        while (idle < 3 && n < 400) begin
            @(negedge clk); #3;
            n++;
            if (fifo.size() == 0 && !busy && !pop_pend) idle++;
            else idle = 0;
        end
        chk(tag, 32'(idle >= 3), 1);
    endtask

    initial begin
        clear_stats();
        // Reset with a byte waiting: nothing may be popped or driven.
        put(8'h00);
        repeat (3) @(negedge clk);
        #3;
        chk("rst_rd", rd, 0);
        chk("rst_flags", {out_valid, out_last, frame_ok, frame_err, busy}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        wait_idle("idle_after_rst");

        // Good frame, sink always ready.
        clear_stats();
        put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h03);
        wait_idle("idle_good");
        chk("good_ok", ok_cnt, 1);
        chk("good_err", err_cnt, 0);
        chk("good_nbytes", outq.size(), 3);
        chk("good_b0", outq[0], 8'h11);
        chk("good_b1", outq[1], 8'h22);
        chk("good_b2", outq[2], 8'h33);
        chk("good_last_cnt", last_cnt, 1);
        chk("good_last_byte", last_byte, 8'h33);
        chk("good_err_code", err_code, 2'b00);

        // Bad checksum.
        clear_stats();
        put(8'hA5); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h07);
        wait_idle("idle_badchk");
        chk("badchk_err", err_cnt, 1);
        chk("badchk_ok", ok_cnt, 0);
        chk("badchk_code", err_code, 2'b10);
        chk("badchk_valid", valid_cnt, 0);

        // Junk then zero length.
        clear_stats();
        put(8'h00); put(8'h7E); put(8'hA5); put(8'h00);
        wait_idle("idle_badlen");
        chk("badlen_err", err_cnt, 1);
        chk("badlen_code", err_code, 2'b01);
        chk("badlen_ok", ok_cnt, 0);
        chk("badlen_busy", busy, 0);

        // Maximum length frame, payload 00..0F, CHK = 10.
        clear_stats();
        put(8'hA5); put(8'h10);
        for (int i = 0; i < 16; i++) put(8'(i));
        put(8'h10);
        wait_idle("idle_maxlen");
        chk("maxlen_ok", ok_cnt, 1);
        chk("maxlen_nbytes", outq.size(), 16);
        chk("maxlen_b7", outq[7], 8'h07);
        chk("maxlen_last", last_byte, 8'h0F);

        // Timeout after A5 02 44.
        clear_stats();
        put(8'hA5); put(8'h02); put(8'h44);
        wait_idle("idle_timeout");
        chk("to_err", err_cnt, 1);
        chk("to_code", err_code, 2'b11);
        chk("to_delay", err_cyc - last_pop_cyc, TO + 1);

        // Length one past MAX_LEN.
        clear_stats();
        put(8'hA5); put(8'h11);
        wait_idle("idle_overlen");
        chk("overlen_err", err_cnt, 1);
        chk("overlen_code", err_code, 2'b01);

        // Stalling sink; payload carries an SOF byte. CHK = 04^A5^01^02^80 = 22.
        clear_stats();
        toggle_mode = 1'b1;
        put(8'hA5); put(8'h04); put(8'hA5); put(8'h01); put(8'h02); put(8'h80); put(8'h22);
        wait_idle("idle_toggle");
        toggle_mode = 1'b0;
        chk("tog_ok", ok_cnt, 1);
        chk("tog_nbytes", outq.size(), 4);
        chk("tog_b0", outq[0], 8'hA5);
        chk("tog_b1", outq[1], 8'h01);
        chk("tog_b2", outq[2], 8'h02);
        chk("tog_b3", outq[3], 8'h80);
        chk("tog_rd_in_emit", rd_emit_viol, 0);
        chk("tog_stable", stall_viol, 0);
        chk("tog_stalled", 32'(stall_cnt > 0), 1);

        // Reset mid-payload, then a good frame.
        clear_stats();
        put(8'hA5); put(8'h05); put(8'h01); put(8'h02);
        begin
            int n = 0;
            while ((fifo.size() != 0 || pop_pend) && n < 50) begin
                @(negedge clk); #3;
                n++;
            end
        end
        @(negedge clk); #3;
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        put(8'hA5); put(8'h01); put(8'h5A); put(8'h5B);
        wait_idle("idle_after_mid");
        chk("mid_err", err_cnt, 0);
        chk("mid_ok", ok_cnt, 1);
        chk("mid_nbytes", outq.size(), 1);
        chk("mid_b0", outq[0], 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5, meaning start-of-frame byte.
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning maximum payload bytes (1..255).
REQ-003 SHALL have parameter TO_CYC, default 1024, meaning inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port rx_empty, input, 1, meaning the UART rx FIFO is empty.
REQ-007 SHALL have port rdata, input, 8, meaning the UART rx FIFO head byte (first-word fall-through), valid when rx_empty=0.
REQ-008 SHALL have port rd, output, 1, meaning pop the UART rx FIFO; the byte on rdata is consumed at this edge.
REQ-009 SHALL have port out_data, output, 8, meaning payload byte.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the sink accepts out_data.
REQ-012 SHALL have port out_last, output, 1, meaning the last payload byte of the frame.
REQ-013 SHALL have port frame_ok, output, 1, meaning a one-cycle pulse when the checksum matches.
REQ-014 SHALL have port frame_err, output, 1, meaning a one-cycle pulse when a frame is aborted.
REQ-015 SHALL have port err_code, output, 2, meaning 01 = bad length, 10 = bad checksum, 11 = timeout; it holds until the next frame_err or reset.
REQ-016 SHALL have port busy, output, 1, meaning the state is not HUNT.

Function
REQ-017 SHALL define the frame format as SOF, LEN, LEN payload bytes, then CHK; CHK = XOR of LEN and all payload bytes.
REQ-018 SHALL implement states HUNT, LEN, PAYLOAD, CHK and EMIT.
REQ-019 SHALL drive rd combinationally: rd = !rx_empty && !rst && state in {HUNT, LEN, PAYLOAD, CHK}; rd SHALL never assert in EMIT.
REQ-020 SHALL, in HUNT, discard popped bytes that are not SOF; a popped SOF SHALL move the block to LEN.
REQ-021 SHALL, in LEN, go to PAYLOAD when the popped byte is in 1..MAX_LEN, latching it as len and seeding the running XOR with it.
REQ-022 SHALL, in LEN, for a popped byte of 0 or greater than MAX_LEN, pulse frame_err with err_code=01 and return to HUNT.
REQ-023 SHALL, in PAYLOAD, write each popped byte to an internal buffer of depth MAX_LEN at index wr_idx, update the XOR, and go to CHK after len bytes.
REQ-024 SHALL, in CHK, on a popped byte equal to the XOR, pulse frame_ok and enter EMIT with rd_idx=0.
REQ-025 SHALL, in CHK, on a mismatch, pulse frame_err with err_code=10, return to HUNT and emit no data.
REQ-026 SHALL, in EMIT, drive out_valid=1, out_data=buffer[rd_idx] and out_last=(rd_idx==len-1).
REQ-027 SHALL advance rd_idx on each out_valid && out_ready, and return to HUNT after the handshake with out_last=1; out_data SHALL hold stable while out_ready=0.
REQ-028 SHALL keep out_valid=0 outside EMIT; the first out_valid cycle is the cycle after the CHK pop.
REQ-029 SHALL run a timeout counter in LEN, PAYLOAD and CHK: it clears on every pop and increments on each cycle with rx_empty=1.
REQ-030 SHALL, when the counter reaches TO_CYC-1, pulse frame_err with err_code=11 and return to HUNT; no timeout applies in HUNT or EMIT.
REQ-031 SHALL treat a popped SOF byte inside LEN/PAYLOAD/CHK as ordinary data (no resync).
REQ-032 SHALL size the internal counters as ceil(log2(MAX_LEN+1)) bits, with no wrap beyond len.
REQ-033 SHALL make frame_ok and frame_err mutually exclusive in any cycle.

Reset
REQ-034 SHALL, while rst=1 at a clk edge, enter HUNT and clear len, the indices, the XOR and the timeout counter.
REQ-035 SHALL, while rst=1 at a clk edge, drive out_valid=0, out_last=0, out_data=0, frame_ok=0, frame_err=0, err_code=00, busy=0 and rd=0.
REQ-036 SHALL, on a reset asserted mid-frame or mid-EMIT, drop the frame without a frame_err pulse.

Verification
REQ-037 SHALL cover: good frame A5 03 11 22 33 03 with out_ready=1 -> frame_ok once; out bytes 11, 22, 33; out_last on 33; err_code=00.
REQ-038 SHALL cover: A5 03 11 22 33 07 -> frame_err with err_code=10; out_valid never 1.
REQ-039 SHALL cover: bytes 00 7E A5 00 -> first two bytes discarded; frame_err with err_code=01; back in HUNT.
REQ-040 SHALL cover: A5 02 44 then rx_empty=1 for TO_CYC cycles -> frame_err with err_code=11 exactly TO_CYC cycles after the last pop.
REQ-041 SHALL cover: good frame with out_ready toggling 1/0 -> rd=0 throughout EMIT; out_data stable while stalled; all bytes in order.
REQ-042 SHALL cover: rst=1 during PAYLOAD, then a good frame -> no pulse at reset; the following frame parsed correctly with frame_ok.
